// File: rtl/lsu_pkg.sv
// lsu_pkg: bundle layouts, memory op codes and FSM states for the load/store stage.
package lsu_pkg;
    localparam int LSU_WBU_BUS_WIDTH = 119;
    localparam int EXU_LSU_BUS_WIDTH = LSU_WBU_BUS_WIDTH + 69;
    localparam logic [2:0] MEM_OP_LB  = 3'b000;
    localparam logic [2:0] MEM_OP_LH  = 3'b001;
    localparam logic [2:0] MEM_OP_LW  = 3'b010;
    localparam logic [2:0] MEM_OP_LBU = 3'b100;
    localparam logic [2:0] MEM_OP_LHU = 3'b101;
    localparam logic [2:0] MEM_OP_SB  = 3'b000;
    localparam logic [2:0] MEM_OP_SH  = 3'b001;
    localparam logic [2:0] MEM_OP_SW  = 3'b010;

    typedef struct packed {
        logic        csr_we;
        logic [31:0] final_result;
        logic        gr_we;
        logic [4:0]  rd;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic        jmp_flag;
        logic [31:0] jmp_target;
        logic        brk;
        logic        excp_flush;
        logic        xret_flush;
    } wbu_bus_t;

    typedef struct packed {
        logic        mem_en;
        logic        mem_we;
        logic [2:0]  mem_op;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        wbu_bus_t    wbu;
    } exu_bus_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte/halfword lane selection for loads, strobe and data replication for stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] result,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic        misalign
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        is_byte;
    logic        is_half;
    // op[2] marks the unsigned load variants; unknown ops fall through to word
    always_comb begin
        is_byte   = op[1:0] == 2'b00;
        is_half   = op[1:0] == 2'b01;
        lane_b    = rdata[{addr, 3'b000} +: 8];
        lane_h    = addr[1] ? rdata[31:16] : rdata[15:0];
        result    = is_byte ? {{24{lane_b[7] & ~op[2]}}, lane_b}
                  : is_half ? {{16{lane_h[15] & ~op[2]}}, lane_h} : rdata;
        wstrb     = is_byte ? 4'b0001 << addr : is_half ? 4'b0011 << addr : 4'b1111;
        wdata_rep = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
        misalign  = is_half ? addr[0] : !is_byte && addr != 2'b00;
    end
endmodule

// File: rtl/lsu.sv
// lsu: non-pipelined load/store stage; one data-memory access per bundle, result pulsed to wbu.
module lsu
    import lsu_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         exu_valid_i,
    input  logic [EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_i,
    output logic                         lsu_ready_o,
    output logic                         lsu_valid_o,
    output logic [LSU_WBU_BUS_WIDTH-1:0] lsu_wbu_bus_o,
    output logic                         lsu_misalign_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [31:0]                  mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    output logic [3:0]                   mem_wstrb_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [31:0]                  mem_rdata_i
);
    exu_bus_t    in_bus;
    wbu_bus_t    out_bus;
    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  addr_q;
    logic        we_q;
    logic [31:0] ld_result;
    logic [31:0] wdata_rep;
    logic [3:0]  wstrb;
    logic        misalign;
    logic        done;

    assign in_bus        = exu_bus_t'(exu_lsu_bus_i);
    assign lsu_ready_o   = state == IDLE;
    assign lsu_wbu_bus_o = out_bus;
    assign done          = (state == REQ && mem_gnt_i && mem_rvalid_i) || (state == WAIT && mem_rvalid_i);

    // In IDLE the aligner checks the incoming bundle; afterwards it decodes the latched one
    lsu_align u_align (
        .op        (lsu_ready_o ? in_bus.mem_op : op_q),
        .addr      (lsu_ready_o ? in_bus.mem_addr[1:0] : addr_q),
        .rdata     (mem_rdata_i),
        .wdata     (in_bus.mem_wdata),
        .result    (ld_result),
        .wstrb     (wstrb),
        .wdata_rep (wdata_rep),
        .misalign  (misalign)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            out_bus        <= '0;
            op_q           <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            lsu_valid_o    <= 1'b0;
            lsu_misalign_o <= 1'b0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            mem_wstrb_o    <= '0;
        end else begin
            if (state == IDLE && exu_valid_i) begin
                out_bus <= in_bus.wbu;
                op_q    <= in_bus.mem_op;
                addr_q  <= in_bus.mem_addr[1:0];
                we_q    <= in_bus.mem_we;
                if (!in_bus.mem_en) begin
                    state       <= RESP;
                    lsu_valid_o <= 1'b1;
                end else if (misalign) begin
                    state                <= RESP;
                    lsu_valid_o          <= 1'b1;
                    lsu_misalign_o       <= 1'b1;
                    out_bus.gr_we        <= 1'b0;
                    out_bus.final_result <= '0;
                end else begin
                    state       <= REQ;
                    mem_req_o   <= 1'b1;
                    mem_we_o    <= in_bus.mem_we;
                    mem_addr_o  <= {in_bus.mem_addr[31:2], 2'b00};
                    mem_wdata_o <= wdata_rep;
                    mem_wstrb_o <= in_bus.mem_we ? wstrb : 4'b0000;
                end
            end
            if (state == REQ && mem_gnt_i) begin
                state     <= WAIT;
                mem_req_o <= 1'b0;
            end
            if (done) begin
                state       <= RESP;
                lsu_valid_o <= 1'b1;
                if (!we_q) out_bus.final_result <= ld_result;
            end
            if (state == RESP) begin
                state          <= IDLE;
                lsu_valid_o    <= 1'b0;
                lsu_misalign_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized bundles checked against a byte-lane memory model.
module tb_lsu;
    import lsu_pkg::*;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic                         exu_valid_i;
    logic [EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_i;
    logic                         lsu_ready_o;
    logic                         lsu_valid_o;
    logic [LSU_WBU_BUS_WIDTH-1:0] lsu_wbu_bus_o;
    logic                         lsu_misalign_o;
    logic                         mem_req_o;
    logic                         mem_we_o;
    logic [31:0]                  mem_addr_o;
    logic [31:0]                  mem_wdata_o;
    logic [3:0]                   mem_wstrb_o;
    logic                         mem_gnt_i;
    logic                         mem_rvalid_i;
    logic [31:0]                  mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    lsu dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .exu_valid_i    (exu_valid_i),
        .exu_lsu_bus_i  (exu_lsu_bus_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_valid_o    (lsu_valid_o),
        .lsu_wbu_bus_o  (lsu_wbu_bus_o),
        .lsu_misalign_o (lsu_misalign_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_wstrb_o    (mem_wstrb_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU: return 1;
            MEM_OP_LH, MEM_OP_LHU: return 2;
            default:               return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] w);
        int sz = access_size(op);
        logic [31:0] lane;
        if (sz == 4) return w;
        lane = (w >> (8 * (addr % 4))) & ((32'd1 << (8 * sz)) - 32'd1);
        if ((op == MEM_OP_LB || op == MEM_OP_LH) && lane >= (32'd1 << (8 * sz - 1)))
            lane = lane - (32'd1 << (8 * sz));
        return lane;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] op, input logic [31:0] addr);
        int sz = access_size(op);
        logic [31:0] m;
        if (sz == 4) return 4'hF;
        m = ((32'd1 << sz) - 32'd1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] w);
        int sz = access_size(op);
        if (sz == 1) return {24'b0, w[7:0]} * 32'h01010101;
        if (sz == 2) return {16'b0, w[15:0]} * 32'h00010001;
        return w;
    endfunction

    function automatic exu_bus_t mk(input bit en, input bit we, input logic [2:0] op,
                                    input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] alu);
        exu_bus_t b;
        b.mem_en              = en;
        b.mem_we              = we;
        b.mem_op              = op;
        b.mem_addr            = addr;
        b.mem_wdata           = wdata;
        b.wbu.csr_we          = 1'($urandom);
        b.wbu.final_result    = alu;
        b.wbu.gr_we           = 1'b1;
        b.wbu.rd              = 5'($urandom);
        b.wbu.csr_addr        = 12'($urandom);
        b.wbu.csr_wdata       = $urandom;
        b.wbu.jmp_flag        = 1'($urandom);
        b.wbu.jmp_target      = $urandom;
        b.wbu.brk             = 1'($urandom);
        b.wbu.excp_flush      = 1'($urandom);
        b.wbu.xret_flush      = 1'($urandom);
        return b;
    endfunction

    // Present one bundle at #1 after an edge; gd = cycles before grant, rd = cycles from grant to response
    task automatic run(input string tag, input exu_bus_t b, input int gd, input int rd, input logic [31:0] rdata);
        wbu_bus_t exp = b.wbu;
        int       sz  = access_size(b.mem_op);
        bit       mis = b.mem_en && (b.mem_addr % sz != 0);
        if (mis) begin
            exp.gr_we        = 1'b0;
            exp.final_result = '0;
        end
        check($sformatf("%s.ready_in", tag), lsu_ready_o, 1);
        exu_valid_i   = 1'b1;
        exu_lsu_bus_i = b;
        @(posedge clk_i); #1;
        exu_valid_i   = 1'b0;
        exu_lsu_bus_i = ~b;
        if (!b.mem_en || mis) begin
            check($sformatf("%s.valid", tag), lsu_valid_o, 1);
            check($sformatf("%s.misalign", tag), lsu_misalign_o, mis);
            check($sformatf("%s.req", tag), mem_req_o, 0);
            check($sformatf("%s.bus", tag), lsu_wbu_bus_o, exp);
        end else begin
            check($sformatf("%s.req", tag), mem_req_o, 1);
            check($sformatf("%s.we", tag), mem_we_o, b.mem_we);
            check($sformatf("%s.addr", tag), mem_addr_o, b.mem_addr & 32'hFFFF_FFFC);
            check($sformatf("%s.wstrb", tag), mem_wstrb_o, b.mem_we ? store_strb(b.mem_op, b.mem_addr) : 4'h0);
            if (b.mem_we) check($sformatf("%s.wdata", tag), mem_wdata_o, store_data(b.mem_op, b.mem_wdata));
            check($sformatf("%s.valid_early", tag), lsu_valid_o, 0);
            repeat (gd) begin
                @(posedge clk_i); #1;
                check($sformatf("%s.req_hold", tag), mem_req_o, 1);
                check($sformatf("%s.addr_hold", tag), mem_addr_o, b.mem_addr & 32'hFFFF_FFFC);
            end
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = rd == 0;
            mem_rdata_i  = rdata;
            @(posedge clk_i); #1;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (rd > 0) begin
                check($sformatf("%s.req_drop", tag), mem_req_o, 0);
                repeat (rd - 1) begin
                    @(posedge clk_i); #1;
                    check($sformatf("%s.valid_wait", tag), lsu_valid_o, 0);
                end
                mem_rvalid_i = 1'b1;
                @(posedge clk_i); #1;
                mem_rvalid_i = 1'b0;
            end
            mem_rdata_i = $urandom;
            if (!b.mem_we) exp.final_result = load_val(b.mem_op, b.mem_addr, rdata);
            check($sformatf("%s.valid", tag), lsu_valid_o, 1);
            check($sformatf("%s.misalign", tag), lsu_misalign_o, 0);
            check($sformatf("%s.bus", tag), lsu_wbu_bus_o, exp);
        end
        @(posedge clk_i); #1;
        check($sformatf("%s.valid_end", tag), lsu_valid_o, 0);
        check($sformatf("%s.ready_end", tag), lsu_ready_o, 1);
        check($sformatf("%s.bus_hold", tag), lsu_wbu_bus_o, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s.ready", tag), lsu_ready_o, 1);
        check($sformatf("%s.valid", tag), lsu_valid_o, 0);
        check($sformatf("%s.misalign", tag), lsu_misalign_o, 0);
        check($sformatf("%s.req", tag), mem_req_o, 0);
        check($sformatf("%s.wstrb", tag), mem_wstrb_o, 0);
        check($sformatf("%s.bus", tag), lsu_wbu_bus_o, 0);
    endtask

    initial begin
        exu_bus_t    b;
        logic [2:0]  ld_ops [5] = '{MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU};
        logic [2:0]  st_ops [3] = '{MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
        rst_i         = 1'b1;
        exu_valid_i   = 1'b0;
        exu_lsu_bus_i = '0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check_reset_outputs("reset");

        run("alu", mk(0, 0, MEM_OP_LW, 32'h0, 32'h0, 32'h1234), 0, 0, 32'h0);
        run("lb", mk(1, 0, MEM_OP_LB, 32'h8000_0003, 32'h0, 32'h55), 2, 2, 32'h8F00_0000);
        run("lbu", mk(1, 0, MEM_OP_LBU, 32'h8000_0003, 32'h0, 32'h55), 2, 2, 32'h8F00_0000);
        run("sh", mk(1, 1, MEM_OP_SH, 32'h8000_0002, 32'hABCD_1234, 32'h8000_0002), 1, 1, 32'hFFFF_FFFF);
        run("lw_mis", mk(1, 0, MEM_OP_LW, 32'h8000_0001, 32'h0, 32'h77), 0, 0, 32'h0);
        run("lw_fast", mk(1, 0, MEM_OP_LW, 32'h8000_0010, 32'h0, 32'h0), 0, 0, 32'hDEAD_BEEF);
        run("lh_hi", mk(1, 0, MEM_OP_LH, 32'h8000_0006, 32'h0, 32'h0), 0, 1, 32'h8001_7FFF);
        run("lhu_lo", mk(1, 0, MEM_OP_LHU, 32'h8000_0004, 32'h0, 32'h0), 1, 0, 32'h8001_F00F);
        run("sb", mk(1, 1, MEM_OP_SB, 32'h8000_0001, 32'h0000_00A5, 32'h99), 0, 0, 32'h0);
        run("sh_mis", mk(1, 1, MEM_OP_SH, 32'h8000_0003, 32'h1111_2222, 32'h42), 0, 0, 32'h0);

        mem_rvalid_i = 1'b1;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        check("stray_idle.valid", lsu_valid_o, 0);
        check("stray_idle.ready", lsu_ready_o, 1);

        for (int i = 0; i < 60; i++) begin
            bit         en = ($urandom % 4) != 0;
            bit         we = $urandom % 2;
            logic [2:0] op = we ? st_ops[$urandom % 3] : ld_ops[$urandom % 5];
            b = mk(en, we, op, $urandom, $urandom, $urandom);
            run($sformatf("rnd%0d", i), b, $urandom % 3, $urandom % 3, $urandom);
            repeat ($urandom % 2) begin
                @(posedge clk_i); #1;
            end
        end

        b = mk(1, 0, MEM_OP_LW, 32'h8000_0020, 32'h0, 32'h0);
        exu_valid_i   = 1'b1;
        exu_lsu_bus_i = b;
        @(posedge clk_i); #1;
        exu_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b0;
        rst_i     = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("rst_wait.req", mem_req_o, 0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1357_9BDF;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        check_reset_outputs("rst_wait");
        @(posedge clk_i); #1;
        check("rst_wait.valid_late", lsu_valid_o, 0);
        run("after_rst", mk(1, 0, MEM_OP_LB, 32'h8000_0002, 32'h0, 32'h0), 0, 0, 32'h0012_3400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
